// File: rtl/unary_pkg.sv
// Shared constants and FSM encoding for the unary adder driver.
package unary_pkg;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned MAX   = 12;
   localparam int unsigned ST_W  = 3;

   typedef logic [ST_W-1:0] state_t;

   localparam logic [ST_W-1:0] S_IDLE  = 3'd0;
   localparam logic [ST_W-1:0] S_DRIVE = 3'd1;
   localparam logic [ST_W-1:0] S_FLUSH = 3'd2;
   localparam logic [ST_W-1:0] S_WRITE = 3'd3;
   localparam logic [ST_W-1:0] S_DONE  = 3'd4;

endpackage

// File: rtl/unary_ser.sv
// Load/decrement counter that emits a registered 1 while its count is nonzero.
module unary_ser #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         step,
   input  logic [W-1:0] val,
   output logic         ser,
   output logic         more_c
);

   logic [W-1:0] cnt;

   // more_c: the stream continues past the current cycle
   assign more_c = (cnt > W'(1));

   // Counter and stream bit; ser always tracks cnt != 0 after each update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         ser <= 1'b0;
      end else if (load) begin
         cnt <= val;
         ser <= (val != '0);
      end else if (step && (cnt != '0)) begin
         cnt <= cnt - W'(1);
         ser <= (cnt > W'(1));
      end
   end

endmodule

// File: rtl/unary_add_driver.sv
// Initiator for the unary adder: serializes operands, then deserializes the sum.
module unary_add_driver
   import unary_pkg::*;
#(
   parameter int unsigned WIDTH = unary_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             A,
   output logic             B,
   output logic             en,
   output logic             read_or_write,
   input  logic             dout,
   input  logic             C
);

   localparam int unsigned CW = WIDTH + 1;

   state_t           state, state_n;
   logic [WIDTH-1:0] acc, acc_n;
   logic [CW-1:0]    wr_cnt, wr_cnt_n;
   logic             fl_cnt, fl_cnt_n;
   logic [WIDTH-1:0] result_n;
   logic             carry_n;
   logic             busy_n, done_n, en_n, rw_n;
   logic             load_c, step_c;
   logic             a_more_c, b_more_c;

   unary_ser #(.W(WIDTH)) u_ser_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load_c),
      .step   (step_c),
      .val    (op_a),
      .ser    (A),
      .more_c (a_more_c)
   );

   unary_ser #(.W(WIDTH)) u_ser_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load_c),
      .step   (step_c),
      .val    (op_b),
      .ser    (B),
      .more_c (b_more_c)
   );

   // Next-state, datapath and next-output logic
   always_comb begin
      state_n  = state;
      acc_n    = acc;
      wr_cnt_n = wr_cnt;
      fl_cnt_n = fl_cnt;
      result_n = result;
      carry_n  = carry;
      load_c   = 1'b0;
      step_c   = 1'b0;

      if (state != S_IDLE) begin
         carry_n = carry | C;
      end

      case (state)
         S_IDLE: begin
            if (start) begin
               load_c   = 1'b1;
               carry_n  = 1'b0;
               acc_n    = '0;
               fl_cnt_n = 1'b0;
               wr_cnt_n = '0;
               state_n  = ((op_a == '0) && (op_b == '0)) ? S_FLUSH : S_DRIVE;
            end
         end
         S_DRIVE: begin
            step_c = 1'b1;
            if (!a_more_c && !b_more_c) begin
               fl_cnt_n = 1'b0;
               state_n  = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (fl_cnt) begin
               wr_cnt_n = '0;
               state_n  = S_WRITE;
            end else begin
               fl_cnt_n = 1'b1;
            end
         end
         S_WRITE: begin
            wr_cnt_n = wr_cnt + CW'(1);
            // First WRITE cycle sees the adder's stale read-phase dout
            if (wr_cnt == CW'(1 << WIDTH)) begin
               result_n = acc;
               state_n  = S_DONE;
            end else if (wr_cnt != '0) begin
               if (dout) begin
                  acc_n = acc + WIDTH'(1);
               end else begin
                  result_n = acc;
                  state_n  = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      en_n   = (state_n == S_DRIVE) || (state_n == S_FLUSH) || (state_n == S_WRITE);
      rw_n   = (state_n == S_WRITE);
      busy_n = en_n;
      done_n = (state_n == S_DONE);
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         acc           <= '0;
         wr_cnt        <= '0;
         fl_cnt        <= 1'b0;
         result        <= '0;
         carry         <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         en            <= 1'b0;
         read_or_write <= 1'b0;
      end else begin
         state         <= state_n;
         acc           <= acc_n;
         wr_cnt        <= wr_cnt_n;
         fl_cnt        <= fl_cnt_n;
         result        <= result_n;
         carry         <= carry_n;
         busy          <= busy_n;
         done          <= done_n;
         en            <= en_n;
         read_or_write <= rw_n;
      end
   end

endmodule

// File: tb/tb_unary_add_driver.sv
// Testbench for unary_add_driver with a behavioural unary adder attached.
module tb_unary_add_driver;
   import unary_pkg::*;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             car;
      int               done_cyc;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] op_a, op_b;
   logic             busy, done, carry;
   logic [WIDTH-1:0] result;
   logic             A, B, en, read_or_write;
   logic             dout, C;

   logic [WIDTH-1:0] add_cnt;
   logic             add_above;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t sb_q[$];

   unary_add_driver #(.WIDTH(WIDTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .op_a          (op_a),
      .op_b          (op_b),
      .busy          (busy),
      .done          (done),
      .result        (result),
      .carry         (carry),
      .A             (A),
      .B             (B),
      .en            (en),
      .read_or_write (read_or_write),
      .dout          (dout),
      .C             (C)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Unary adder: counts A/B ones in read phase, pulses C on crossing MAX, streams count out in write phase
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         add_cnt   <= '0;
         add_above <= 1'b0;
         C         <= 1'b0;
         dout      <= 1'b0;
      end else begin
         C         <= 1'b0;
         dout      <= 1'b0;
         add_above <= (int'(add_cnt) > int'(MAX));
         if (en && !read_or_write) begin
            add_cnt <= add_cnt + WIDTH'(A) + WIDTH'(B);
            C       <= (int'(add_cnt) > int'(MAX)) && !add_above;
         end else if (en && read_or_write) begin
            dout <= (add_cnt != '0);
            if (add_cnt != '0) add_cnt <= add_cnt - WIDTH'(1);
         end
      end
   end

   // Scoreboard: every done pulse must match the oldest expected operation
   always @(negedge clk) begin
      if (rst_n && done) begin
         exp_t e;
         checks = checks + 1;
         if (sb_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_done: done seen at cycle %0d with no operation pending", cyc);
         end else begin
            e = sb_q.pop_front();
            if (result !== e.res || carry !== e.car || busy !== 1'b0 || cyc != e.done_cyc) begin
               errors = errors + 1;
               $display("FAIL done_result: got result=%0d carry=%0b busy=%0b cycle=%0d, expected result=%0d carry=%0b busy=0 cycle=%0d",
                        result, carry, busy, cyc, e.res, e.car, e.done_cyc);
            end
         end
      end
   end

   // Issue one operation and follow it to done; optionally re-pulse start at cycle index repulse
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int repulse,
                         output int na, output int nb, output int nab, output logic busy1, output bit to);
      exp_t e;
      int   mx;
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      mx    = (a > b) ? int'(a) : int'(b);
      e.res = WIDTH'(int'(a) + int'(b));
      e.car = (int'(a) + int'(b)) > int'(MAX);
      e.done_cyc = cyc + mx + 2 + int'(e.res) + 2 + 1;
      sb_q.push_back(e);
      na = 0; nb = 0; nab = 0; to = 1'b1; busy1 = 1'b0;
      @(negedge clk);
      start = 1'b0;
      busy1 = busy;
      for (int n = 1; n < 200; n++) begin
         na  += int'(A);
         nb  += int'(B);
         nab += int'(A & B);
         if (done) begin
            to = 1'b0;
            break;
         end
         @(negedge clk);
         start = (n + 1 == repulse);
         op_a  = ~a;
         op_b  = ~b;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({A, B, en, read_or_write, busy, done, carry, result} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got A=%0b B=%0b en=%0b rw=%0b busy=%0b done=%0b carry=%0b result=%0d, expected all 0",
                  A, B, en, read_or_write, busy, done, carry, result);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({A, B, en, read_or_write, busy, done, carry, result} !== '0) begin
         errors++;
         $display("FAIL idle_outputs: got en=%0b busy=%0b done=%0b result=%0d, expected all 0", en, busy, done, result);
      end
   endtask

   task automatic test_basic();
      int na, nb, nab; logic b1; bit to;
      run_op(4'd3, 4'd4, -1, na, nb, nab, b1, to);
      checks++;
      if (to) begin errors++; $display("FAIL basic_timeout: done not seen, expected within 200 cycles"); end
      checks++;
      if (na != 3 || nb != 4 || nab != 3) begin
         errors++;
         $display("FAIL basic_streams: got A=%0d B=%0d both=%0d cycles, expected 3 4 3", na, nb, nab);
      end
      checks++;
      if (b1 !== 1'b1) begin errors++; $display("FAIL basic_busy: got busy=%0b after start, expected 1", b1); end
      repeat (4) @(negedge clk);
      checks++;
      if (result !== 4'd7 || carry !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL basic_hold: got result=%0d carry=%0b busy=%0b done=%0b, expected 7 0 0 0", result, carry, busy, done);
      end
   endtask

   task automatic test_threshold();
      int na, nb, nab; logic b1; bit to;
      run_op(4'd12, 4'd1, -1, na, nb, nab, b1, to);
      checks++;
      if (to || na != 12 || nb != 1 || nab != 1) begin
         errors++;
         $display("FAIL thresh_streams: got timeout=%0b A=%0d B=%0d both=%0d, expected 0 12 1 1", to, na, nb, nab);
      end
      @(negedge clk);
      checks++;
      if (result !== 4'd13 || carry !== 1'b1) begin
         errors++;
         $display("FAIL thresh_result: got result=%0d carry=%0b, expected 13 1", result, carry);
      end
   endtask

   task automatic test_zero();
      int na, nb, nab; logic b1; bit to;
      run_op(4'd0, 4'd0, -1, na, nb, nab, b1, to);
      checks++;
      if (to || na != 0 || nb != 0) begin
         errors++;
         $display("FAIL zero_streams: got timeout=%0b A=%0d B=%0d, expected 0 0 0", to, na, nb);
      end
      @(negedge clk);
      checks++;
      if (result !== 4'd0 || carry !== 1'b0) begin
         errors++;
         $display("FAIL zero_result: got result=%0d carry=%0b, expected 0 0", result, carry);
      end
   endtask

   task automatic test_back_to_back();
      int na, nb, nab; logic b1; bit to;
      run_op(4'd15, 4'd15, -1, na, nb, nab, b1, to);
      checks++;
      if (to || na != 15 || nb != 15 || nab != 15) begin
         errors++;
         $display("FAIL wrap_streams: got timeout=%0b A=%0d B=%0d both=%0d, expected 0 15 15 15", to, na, nb, nab);
      end
      run_op(4'd6, 4'd6, -1, na, nb, nab, b1, to);
      checks++;
      if (to) begin errors++; $display("FAIL b2b_timeout: done not seen, expected within 200 cycles"); end
      @(negedge clk);
      checks++;
      if (result !== 4'd12 || carry !== 1'b0) begin
         errors++;
         $display("FAIL b2b_result: got result=%0d carry=%0b, expected 12 0", result, carry);
      end
   endtask

   task automatic test_ignored_start();
      int na, nb, nab; logic b1; bit to; int extra_busy;
      run_op(4'd5, 4'd2, 3, na, nb, nab, b1, to);
      checks++;
      if (to || na != 5 || nb != 2) begin
         errors++;
         $display("FAIL ignore_streams: got timeout=%0b A=%0d B=%0d, expected 0 5 2", to, na, nb);
      end
      extra_busy = 0;
      repeat (20) begin
         @(negedge clk);
         extra_busy += int'(busy | done);
      end
      checks++;
      if (extra_busy != 0 || result !== 4'd7) begin
         errors++;
         $display("FAIL ignore_result: got extra busy/done cycles=%0d result=%0d, expected 0 7", extra_busy, result);
      end
   endtask

   task automatic test_reset_mid_write();
      int na, nb, nab; logic b1; bit to; bit seen;
      @(negedge clk);
      op_a = 4'd3; op_b = 4'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen  = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (read_or_write) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL rst_wait: got no write phase, expected one within 100 cycles"); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({A, B, en, read_or_write, busy, done, carry, result} !== '0) begin
         errors++;
         $display("FAIL rst_async: got en=%0b rw=%0b busy=%0b carry=%0b result=%0d, expected all 0",
                  en, read_or_write, busy, carry, result);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_op(4'd2, 4'd2, -1, na, nb, nab, b1, to);
      @(negedge clk);
      checks++;
      if (to || result !== 4'd4 || carry !== 1'b0) begin
         errors++;
         $display("FAIL rst_recover: got timeout=%0b result=%0d carry=%0b, expected 0 4 0", to, result, carry);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_threshold();
      test_zero();
      test_back_to_back();
      test_ignored_start();
      test_reset_mid_write();
      repeat (5) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending operations, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
